dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequences and shares the single-port, byte-addressed data memory between two requesters: the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write, byte/half/word).
- Arbitrates between them, aligns store data into byte lanes and builds the write mask.
- Waits a fixed memory read latency, then extracts and sign/zero-extends load data and returns it through a valid/ready response channel.
- Sits between IFU/LSU and the memory macro; it is the only master of the memory port.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from the issue cycle to mem_rdata valid (1..7).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ifu_valid  in  1  IFU read request
- ifu_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU word address (must be 4-aligned)
- ifu_rvalid  out  1  IFU response valid
- ifu_rready  in  1  IFU response accept
- ifu_rdata  out  32  fetched word
- ifu_err  out  1  misaligned fetch
- lsu_valid  in  1  LSU request
- lsu_ready  out  1  LSU request accepted this cycle
- lsu_we  in  1  1 = store, 0 = load
- lsu_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as misaligned)
- lsu_unsigned  in  1  load zero-extend
- lsu_addr  in  ADDR_W  byte address
- lsu_wdata  in  32  store data, right-justified
- lsu_rvalid  out  1  LSU response valid (loads and stores)
- lsu_rready  in  1  LSU response accept
- lsu_rdata  out  32  extended load data; 0 for stores
- lsu_err  out  1  misaligned access
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable
- mem_wmask  out  4  byte-lane write mask
- mem_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}
- mem_wdata  out  32  lane-aligned store data
- mem_rdata  in  32  read word, valid MEM_LAT cycles after the issue cycle

Behaviour:
- Reset (asynchronous): state IDLE, last_grant = LSU, and all outputs 0 (ready, rvalid, rdata, err, mem_*).
- States:
  - IDLE: ready outputs are combinational. If only one requester is valid, that requester gets ready. If both are valid, grant goes to the requester not in last_grant (round-robin). Ready is asserted only in IDLE.
  - Accept (valid and ready at the edge): latch the request and update last_grant. If the access is misaligned (half with addr[0]=1, word with addr[1:0]≠0, size 3, or IFU addr[1:0]≠0), go to RESP with err=1 and no memory access. Otherwise go to ISSUE.
  - ISSUE (1 cycle): mem_en=1 and mem_addr is driven.
    - Store: mem_we=1; mem_wdata = wdata shifted left by 8·addr[1:0]; mem_wmask = 0001/0011/1111 shifted left by addr[1:0]. The store completes at this edge, then go to RESP.
    - Load: go to WAIT with the counter set to MEM_LAT-1.
  - WAIT: counter decrements each cycle. In the cycle where the counter is 0, capture mem_rdata, then go to RESP.
  - RESP: rvalid for the granted requester is held high with stable rdata/err until rready. At the handshake edge, go to IDLE. A new request cannot be accepted in that same cycle.
- Load extraction: shift the captured word right by 8·addr[1:0], take 8/16/32 bits, then sign-extend unless lsu_unsigned. IFU data is the full word.
- Latency (accept cycle = 0):
  - Load: rvalid in cycle 2+MEM_LAT.
  - Store: rvalid in cycle 2.
  - Misaligned: rvalid in cycle 1.
- Only one transaction is outstanding at a time. The inactive requester's rvalid is always 0.
- mem_* outputs are 0 in every state other than ISSUE.
- Reset asserted mid-transaction: the transaction is dropped and no response is issued. A store already past ISSUE has been committed.
- Request inputs are sampled only at acceptance. Requester changes after acceptance have no effect.

Decomposition:
- Package dmem_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - size encodings SZ_B=0, SZ_H=1, SZ_W=2;
  - the requester id enum (REQ_IFU, REQ_LSU).
- One combinational sub-module, dmem_lane_align, holds all byte-lane logic: store shift, mask generation, load extract/extend and the misalignment check. The FSM and arbiter stay in the top module.

Test Plan:
- LSU store word 0xDEADBEEF at 0x10, then load word at 0x10 (MEM_LAT=1) -> ISSUE with mask 1111; load rvalid 3 cycles after accept; rdata 0xDEADBEEF.
- Store byte 0x80 at 0x13, then load byte signed and unsigned at 0x13 -> mem_wmask 1000, mem_wdata 0x80000000; rdata 0xFFFFFF80 signed and 0x00000080 unsigned.
- LSU load half at 0x21 -> no mem_en at any point; lsu_rvalid next cycle with lsu_err=1 and rdata 0.
- IFU and LSU both valid and held valid after reset -> grants in order IFU, LSU, IFU (strict alternation). The inactive rvalid stays 0.
- Hold lsu_rready=0 for 5 cycles in RESP -> rvalid/rdata stable; ifu_ready stays 0 even with ifu_valid=1.
- Assert rst_n=0 during WAIT with MEM_LAT=3 -> all outputs 0 immediately; no response after release; the next request is served normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory arbiter.
//   state_t : arbiter FSM states
//   SZ_*    : LSU access-size encodings (3 is reserved and always misaligned)
//   req_t   : requester identifier used for grant tracking
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic {
      REQ_IFU = 1'b0,
      REQ_LSU = 1'b1
   } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: purely combinational byte-lane logic.
//   is_ifu     in  : request comes from the IFU (word fetch, no extension)
//   addr_lo    in  : byte offset within the word
//   size       in  : SZ_B / SZ_H / SZ_W (3 = reserved)
//   zext       in  : zero-extend loads instead of sign-extending
//   wdata      in  : right-justified store data
//   rword      in  : raw word read from memory
//   misaligned out : access cannot be served
//   wmask      out : byte-lane write mask
//   wdata_lane out : store data shifted into its byte lanes
//   rdata_ext  out : extracted and extended load data
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic        is_ifu,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        zext,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic        misaligned,
   output logic [3:0]  wmask,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext
);

   logic [3:0]  base_mask;
   logic [31:0] shifted;

   always_comb begin
      base_mask  = 4'b0000;
      misaligned = 1'b1;
      case (size)
         SZ_B: begin base_mask = 4'b0001; misaligned = 1'b0;               end
         SZ_H: begin base_mask = 4'b0011; misaligned = addr_lo[0];         end
         SZ_W: begin base_mask = 4'b1111; misaligned = (addr_lo != 2'b00); end
         default: ;
      endcase
      // Fetches are always full words regardless of the LSU size field.
      if (is_ifu) misaligned = (addr_lo != 2'b00);
   end

   assign wmask      = base_mask << addr_lo;
   assign wdata_lane = wdata << {addr_lo, 3'b000};
   assign shifted    = rword >> {addr_lo, 3'b000};

   always_comb begin
      rdata_ext = shifted;
      if (is_ifu) begin
         rdata_ext = rword;
      end else begin
         case (size)
            SZ_B: rdata_ext = zext ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H: rdata_ext = zext ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
            default: rdata_ext = shifted;
         endcase
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the IFU (read-only)
// and the LSU (byte/half/word loads and stores). One transaction at a time.
//   ifu_*  : IFU request (valid/ready) and response (rvalid/rready) channels
//   lsu_*  : LSU request and response channels
//   mem_*  : memory macro port, active only in the ISSUE cycle
// Handshakes: a request transfers on the edge where valid && ready; a
// response transfers on the edge where rvalid && rready; rvalid, rdata and
// err hold steady until that edge.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int MEM_LAT = 1,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ifu_valid,
   output logic              ifu_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_rvalid,
   input  logic              ifu_rready,
   output logic [31:0]       ifu_rdata,
   output logic              ifu_err,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic              lsu_we,
   input  logic [1:0]        lsu_size,
   input  logic              lsu_unsigned,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [31:0]       lsu_wdata,
   output logic              lsu_rvalid,
   input  logic              lsu_rready,
   output logic [31:0]       lsu_rdata,
   output logic              lsu_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_wmask,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   state_t      state;
   req_t        last_grant, gnt, cur;
   logic [1:0]  r_addr_lo, r_size;
   logic        r_zext, r_we;
   logic [2:0]  cnt;

   logic              idle, accept, cur_we;
   logic [ADDR_W-1:0] cur_addr;
   logic              al_is_ifu, al_zext;
   logic [1:0]        al_addr_lo, al_size;
   logic              al_misaligned;
   logic [3:0]        al_wmask;
   logic [31:0]       al_wdata, al_rdata;

   // Round-robin: on contention the requester not served last wins.
   assign idle      = (state == IDLE) && rst_n;
   assign ifu_ready = idle && ifu_valid && (!lsu_valid || last_grant == REQ_LSU);
   assign lsu_ready = idle && lsu_valid && (!ifu_valid || last_grant == REQ_IFU);
   assign accept    = ifu_ready || lsu_ready;
   assign cur       = ifu_ready ? REQ_IFU : REQ_LSU;
   assign cur_addr  = ifu_ready ? ifu_addr : lsu_addr;
   assign cur_we    = !ifu_ready && lsu_we;

   // The lane aligner looks at the incoming request while idle (misalignment
   // check, store lanes) and at the latched request afterwards (load extract).
   always_comb begin
      if (state == IDLE) begin
         al_is_ifu  = ifu_ready;
         al_addr_lo = cur_addr[1:0];
         al_size    = lsu_size;
         al_zext    = lsu_unsigned;
      end else begin
         al_is_ifu  = (gnt == REQ_IFU);
         al_addr_lo = r_addr_lo;
         al_size    = r_size;
         al_zext    = r_zext;
      end
   end

   dmem_lane_align u_align (
      .is_ifu     (al_is_ifu),
      .addr_lo    (al_addr_lo),
      .size       (al_size),
      .zext       (al_zext),
      .wdata      (lsu_wdata),
      .rword      (mem_rdata),
      .misaligned (al_misaligned),
      .wmask      (al_wmask),
      .wdata_lane (al_wdata),
      .rdata_ext  (al_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= REQ_LSU;
         gnt        <= REQ_LSU;
         r_addr_lo  <= 2'b00;
         r_size     <= 2'b00;
         r_zext     <= 1'b0;
         r_we       <= 1'b0;
         cnt        <= 3'd0;
         ifu_rvalid <= 1'b0;
         ifu_rdata  <= 32'h0;
         ifu_err    <= 1'b0;
         lsu_rvalid <= 1'b0;
         lsu_rdata  <= 32'h0;
         lsu_err    <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_wmask  <= 4'b0000;
         mem_addr   <= '0;
         mem_wdata  <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  gnt        <= cur;
                  last_grant <= cur;
                  r_addr_lo  <= cur_addr[1:0];
                  r_size     <= lsu_size;
                  r_zext     <= lsu_unsigned;
                  r_we       <= cur_we;
                  if (al_misaligned) begin
                     // Rejected without touching memory.
                     if (ifu_ready) begin
                        ifu_rvalid <= 1'b1;
                        ifu_err    <= 1'b1;
                     end else begin
                        lsu_rvalid <= 1'b1;
                        lsu_err    <= 1'b1;
                     end
                     state <= RESP;
                  end else begin
                     mem_en    <= 1'b1;
                     mem_we    <= cur_we;
                     mem_addr  <= {cur_addr[ADDR_W-1:2], 2'b00};
                     mem_wmask <= cur_we ? al_wmask : 4'b0000;
                     mem_wdata <= cur_we ? al_wdata : 32'h0;
                     state     <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               mem_en    <= 1'b0;
               mem_we    <= 1'b0;
               mem_wmask <= 4'b0000;
               mem_addr  <= '0;
               mem_wdata <= 32'h0;
               if (r_we) begin
                  lsu_rvalid <= 1'b1;
                  state      <= RESP;
               end else begin
                  cnt   <= 3'(MEM_LAT - 1);
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == 3'd0) begin
                  if (gnt == REQ_IFU) begin
                     ifu_rvalid <= 1'b1;
                     ifu_rdata  <= al_rdata;
                  end else begin
                     lsu_rvalid <= 1'b1;
                     lsu_rdata  <= al_rdata;
                  end
                  state <= RESP;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            RESP: begin
               if ((ifu_rvalid && ifu_rready) || (lsu_rvalid && lsu_rready)) begin
                  ifu_rvalid <= 1'b0;
                  ifu_rdata  <= 32'h0;
                  ifu_err    <= 1'b0;
                  lsu_rvalid <= 1'b0;
                  lsu_rdata  <= 32'h0;
                  lsu_err    <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a small memory model
// (MEM_LAT = 3) that returns junk outside the valid read-data cycle.
module tb_dmem_arbiter;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ifu_valid = 1'b0, ifu_ready, ifu_rvalid, ifu_rready = 1'b0, ifu_err;
   logic [31:0] ifu_addr = 32'h0, ifu_rdata;
   logic        lsu_valid = 1'b0, lsu_ready, lsu_we = 1'b0, lsu_unsigned = 1'b0;
   logic [1:0]  lsu_size = 2'd0;
   logic [31:0] lsu_addr = 32'h0, lsu_wdata = 32'h0, lsu_rdata;
   logic        lsu_rvalid, lsu_rready = 1'b0, lsu_err;
   logic        mem_en, mem_we;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.MEM_LAT(LAT), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_addr(ifu_addr),
      .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
      .ifu_err(ifu_err),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_we(lsu_we),
      .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned), .lsu_addr(lsu_addr),
      .lsu_wdata(lsu_wdata), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
      .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_wmask(mem_wmask),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // ---------------- memory model ----------------
   logic [31:0] mem_words [64];
   logic        rd_v [LAT];
   logic [31:0] rd_d [LAT];

   initial begin
      for (int i = 0; i < 64; i++) mem_words[i] = 32'h0;
      for (int i = 0; i < LAT; i++) begin rd_v[i] = 1'b0; rd_d[i] = 32'h0; end
   end

   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) begin
         rd_v[i] <= rd_v[i-1];
         rd_d[i] <= rd_d[i-1];
      end
      rd_v[0] <= mem_en && !mem_we;
      rd_d[0] <= mem_words[mem_addr[7:2]];
      if (mem_en && mem_we)
         for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) mem_words[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
   end

   assign mem_rdata = rd_v[LAT-1] ? rd_d[LAT-1] : 32'h5A5A_A5A5;

   // ---------------- monitors (sampled on the falling edge) ----------------
   int          en_cnt = 0, both_cnt = 0, idle_bad = 0, late_resp = 0;
   logic        iss_we;
   logic [3:0]  iss_mask;
   logic [31:0] iss_addr, iss_wdata;
   logic        arb_win = 1'b0, watch_win = 1'b0;
   logic        grant_q [$];
   logic [31:0] arb_ifu_rd = 32'h0, arb_lsu_rd = 32'h0;

   always @(negedge clk) begin
      if (mem_en) begin
         en_cnt++;
         iss_we = mem_we; iss_mask = mem_wmask; iss_addr = mem_addr; iss_wdata = mem_wdata;
      end else if (mem_we || mem_wmask != 4'b0 || mem_addr != 32'h0 || mem_wdata != 32'h0) begin
         idle_bad++;
      end
      if (ifu_rvalid && lsu_rvalid) both_cnt++;
      if (arb_win) begin
         if (ifu_valid && ifu_ready) grant_q.push_back(1'b0);
         if (lsu_valid && lsu_ready) grant_q.push_back(1'b1);
         if (ifu_rvalid) arb_ifu_rd = ifu_rdata;
         if (lsu_rvalid) arb_lsu_rd = lsu_rdata;
      end
      if (watch_win && (lsu_rvalid || ifu_rvalid)) late_resp++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- check and driver tasks ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // LSU transaction; returns data, err and cycles from accept to rvalid.
   // With hold > 0 the response is left pending for hold cycles while IFU
   // requests, and stability plus blocked IFU acceptance are checked.
   task automatic lsu_txn(input logic we, input logic [1:0] size, input logic zext,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                          output logic [31:0] rd, output logic er, output int lat);
      int k;
      lsu_valid = 1'b1; lsu_we = we; lsu_size = size; lsu_unsigned = zext;
      lsu_addr = addr; lsu_wdata = wdata; lsu_rready = 1'b0;
      #1;
      k = 0;
      while (!lsu_ready && k < 20) begin @(posedge clk); #1; k++; end
      check("lsu_accept", {31'h0, lsu_ready}, 32'h1);
      @(posedge clk); #1;
      // Scramble request fields: only the accepted values may matter.
      lsu_valid = 1'b0; lsu_addr = addr ^ 32'h3; lsu_wdata = ~wdata;
      lsu_size = ~size; lsu_unsigned = ~zext; lsu_we = ~we;
      k = 1;
      while (!lsu_rvalid && k < 30) begin @(posedge clk); #1; k++; end
      lat = k; rd = lsu_rdata; er = lsu_err;
      if (hold > 0) ifu_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_rvalid", {31'h0, lsu_rvalid}, 32'h1);
         check("hold_rdata", lsu_rdata, rd);
         check("hold_ifu_ready", {31'h0, ifu_ready}, 32'h0);
         check("hold_ifu_rvalid", {31'h0, ifu_rvalid}, 32'h0);
      end
      lsu_rready = 1'b1;
      #1;
      if (hold > 0) check("resp_cycle_ifu_ready", {31'h0, ifu_ready}, 32'h0);
      @(posedge clk); #1;
      lsu_rready = 1'b0;
      check("lsu_rvalid_drop", {31'h0, lsu_rvalid}, 32'h0);
   endtask

   task automatic ifu_txn(input logic [31:0] addr, output logic [31:0] rd,
                          output logic er, output int lat);
      int k;
      ifu_valid = 1'b1; ifu_addr = addr; ifu_rready = 1'b0;
      #1;
      k = 0;
      while (!ifu_ready && k < 20) begin @(posedge clk); #1; k++; end
      check("ifu_accept", {31'h0, ifu_ready}, 32'h1);
      @(posedge clk); #1;
      ifu_valid = 1'b0; ifu_addr = 32'hFFFF_FFFF;
      k = 1;
      while (!ifu_rvalid && k < 30) begin @(posedge clk); #1; k++; end
      lat = k; rd = ifu_rdata; er = ifu_err;
      check("ifu_lsu_rvalid_idle", {31'h0, lsu_rvalid}, 32'h0);
      ifu_rready = 1'b1;
      @(posedge clk); #1;
      ifu_rready = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   logic [31:0] rd;
   logic        er;
   int          lat, en0;

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready",  {30'h0, ifu_ready, lsu_ready}, 32'h0);
      check("rst_rvalid", {28'h0, ifu_rvalid, lsu_rvalid, ifu_err, lsu_err}, 32'h0);
      check("rst_rdata",  ifu_rdata | lsu_rdata, 32'h0);
      check("rst_mem",    {26'h0, mem_en, mem_we, mem_wmask}, 32'h0);
      check("rst_mem_ad", mem_addr | mem_wdata, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Store word then load word
      lsu_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, rd, er, lat);
      check("sw_lat", lat, 2);
      check("sw_rdata_err", {rd[30:0], er}, 32'h0);
      check("sw_mask", {27'h0, iss_we, iss_mask}, 32'h1F);
      check("sw_wdata", iss_wdata, 32'hDEAD_BEEF);
      check("sw_addr", iss_addr, 32'h10);
      lsu_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
      check("lw_lat", lat, 2 + LAT);
      check("lw_rdata", rd, 32'hDEAD_BEEF);

      // Store byte / half, signed and unsigned extraction
      lsu_txn(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_0080, 0, rd, er, lat);
      check("sb_mask", {27'h0, iss_we, iss_mask}, 32'h18);
      check("sb_wdata", iss_wdata, 32'h8000_0000);
      check("sb_addr", iss_addr, 32'h10);
      lsu_txn(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, rd, er, lat);
      check("lb_signed", rd, 32'hFFFF_FF80);
      lsu_txn(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, rd, er, lat);
      check("lbu", rd, 32'h0000_0080);
      lsu_txn(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0, rd, er, lat);
      check("lb_lane1", rd, 32'hFFFF_FFBE);
      lsu_txn(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, rd, er, lat);
      check("lh_signed", rd, 32'hFFFF_80AD);
      lsu_txn(1'b1, 2'd1, 1'b0, 32'h16, 32'hFFFF_1234, 0, rd, er, lat);
      check("sh_mask", {27'h0, iss_we, iss_mask}, 32'h1C);
      check("sh_wdata", iss_wdata, 32'h1234_0000);
      lsu_txn(1'b0, 2'd1, 1'b1, 32'h16, 32'h0, 0, rd, er, lat);
      check("lhu", rd, 32'h0000_1234);

      // Misaligned accesses: no memory access, response next cycle
      en0 = en_cnt;
      lsu_txn(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 0, rd, er, lat);
      check("mis_h_lat", lat, 1);
      check("mis_h_err", {31'h0, er}, 32'h1);
      check("mis_h_rdata", rd, 32'h0);
      lsu_txn(1'b1, 2'd2, 1'b0, 32'h22, 32'h1111_1111, 0, rd, er, lat);
      check("mis_w_err", {31'h0, er}, 32'h1);
      lsu_txn(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 0, rd, er, lat);
      check("mis_sz3_err", {31'h0, er}, 32'h1);
      ifu_txn(32'h2, rd, er, lat);
      check("ifu_mis_lat", lat, 1);
      check("ifu_mis_err", {31'h0, er}, 32'h1);
      check("mis_no_mem", en_cnt, en0);

      // Aligned fetch
      ifu_txn(32'h14, rd, er, lat);
      check("ifu_lat", lat, 2 + LAT);
      check("ifu_rdata", rd, 32'h1234_0000);
      check("ifu_err", {31'h0, er}, 32'h0);

      // Response held for 5 cycles; IFU waits, then is served
      lsu_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, rd, er, lat);
      check("hold_rd", rd, 32'h80AD_BEEF);
      ifu_txn(32'h10, rd, er, lat);
      check("after_hold_ifu", rd, 32'h80AD_BEEF);

      // Both requesters held valid from reset: strict alternation
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      ifu_addr = 32'h10; ifu_valid = 1'b1; ifu_rready = 1'b1;
      lsu_addr = 32'h14; lsu_we = 1'b0; lsu_size = 2'd2; lsu_unsigned = 1'b0;
      lsu_valid = 1'b1; lsu_rready = 1'b1;
      arb_win = 1'b1;
      repeat (26) @(posedge clk);
      #1;
      arb_win = 1'b0; ifu_valid = 1'b0; lsu_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      ifu_rready = 1'b0; lsu_rready = 1'b0;
      check("arb_count_ge3", {31'h0, grant_q.size() >= 3}, 32'h1);
      check("arb_g0_ifu", {31'h0, grant_q[0]}, 32'h0);
      check("arb_g1_lsu", {31'h0, grant_q[1]}, 32'h1);
      check("arb_g2_ifu", {31'h0, grant_q[2]}, 32'h0);
      check("arb_ifu_rd", arb_ifu_rd, 32'h80AD_BEEF);
      check("arb_lsu_rd", arb_lsu_rd, 32'h1234_0000);

      // Reset during WAIT drops the load
      lsu_valid = 1'b1; lsu_we = 1'b0; lsu_size = 2'd2; lsu_addr = 32'h10;
      #1;
      check("rw_ready", {31'h0, lsu_ready}, 32'h1);
      @(posedge clk); #1;
      lsu_valid = 1'b0;
      check("rw_issue", {31'h0, mem_en}, 32'h1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rw_rst_rvalid", {30'h0, ifu_rvalid, lsu_rvalid}, 32'h0);
      check("rw_rst_mem", {26'h0, mem_en, mem_we, mem_wmask}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      lsu_rready = 1'b1; watch_win = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      watch_win = 1'b0; lsu_rready = 1'b0;
      check("rw_no_resp", late_resp, 0);
      lsu_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er, lat);
      check("rw_next_lat", lat, 2 + LAT);
      check("rw_next_rd", rd, 32'h80AD_BEEF);

      // Global invariants
      check("never_both_rvalid", both_cnt, 0);
      check("mem_zero_outside_issue", idle_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
